// File: rtl/simframe_pkg.sv
// Shared types and widths for the simulated-frame pattern scheduler.
package simframe_pkg;

    localparam int unsigned REPEAT_W = 16;
    localparam int unsigned COUNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_DRAIN
    } sched_state_e;

endpackage

// File: rtl/pattern_table.sv
// Pattern/repeat table: one write port, one registered read port, no reset on contents.
module pattern_table #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned DW    = 48,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/simframe_sched.sv
// Plays the pattern table into the frame generator and counts completed frames on its output.
module simframe_sched
    import simframe_pkg::*;
#(
    parameter  int unsigned PATTERN_WIDTH = 32,
    parameter  int unsigned TABLE_DEPTH   = 16,
    localparam int unsigned AW            = $clog2(TABLE_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     CFG_WR_EN,
    input  logic [AW-1:0]            CFG_WR_ADDR,
    input  logic [PATTERN_WIDTH-1:0] CFG_WR_PATTERN,
    input  logic [15:0]              CFG_WR_REPEAT,
    input  logic [AW:0]              SEQ_LENGTH,
    input  logic [15:0]              LOOP_COUNT,
    input  logic [15:0]              ROWS_PER_FRAME,
    input  logic                     START,
    input  logic                     STOP,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [31:0]              FRAMES_ISSUED,
    output logic [31:0]              FRAMES_DONE,
    output logic [PATTERN_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                     AXIS_OUT_TVALID,
    input  logic                     AXIS_OUT_TREADY,
    input  logic                     MON_TVALID,
    input  logic                     MON_TREADY,
    input  logic                     MON_TLAST
);

    localparam int unsigned EW = PATTERN_WIDTH + REPEAT_W;

    sched_state_e               state_q, state_d;
    logic [AW-1:0]              idx_q, idx_d;
    logic [AW:0]                seq_len_q, seq_len_d;
    logic [REPEAT_W-1:0]        pass_q, pass_d;
    logic [REPEAT_W-1:0]        loop_q, loop_d;
    logic [REPEAT_W-1:0]        rep_q, rep_d;
    logic [15:0]                row_q, row_d;
    logic [15:0]                rpf_q, rpf_d;
    logic [COUNT_W-1:0]         issued_q, issued_d;
    logic [COUNT_W-1:0]         fdone_q, fdone_d;
    logic [PATTERN_WIDTH-1:0]   data_q, data_d;
    logic                       stop_q, stop_d;
    logic                       done_q, done_d;

    logic                       tbl_wr_en;
    logic                       tbl_rd_en;
    logic [EW-1:0]              tbl_rd_data;
    logic [REPEAT_W-1:0]        tbl_rep;

    assign tbl_wr_en = CFG_WR_EN && (state_q == ST_IDLE);
    // Read is addressed with the next index so the entry is ready during FETCH.
    assign tbl_rd_en = (state_d == ST_FETCH);
    assign tbl_rep   = tbl_rd_data[EW-1 -: REPEAT_W];

    pattern_table #(
        .DEPTH (TABLE_DEPTH),
        .DW    (EW)
    ) u_table (
        .clk     (clk),
        .wr_en   (tbl_wr_en),
        .wr_addr (CFG_WR_ADDR),
        .wr_data ({CFG_WR_REPEAT, CFG_WR_PATTERN}),
        .rd_en   (tbl_rd_en),
        .rd_addr (idx_d),
        .rd_data (tbl_rd_data)
    );

    always_comb begin
        logic        mon_beat;
        logic        stop_pend;
        logic        last_pass;
        logic [15:0] rpf_last;
        logic [AW:0] seq_last;

        state_d   = state_q;
        idx_d     = idx_q;
        seq_len_d = seq_len_q;
        pass_d    = pass_q;
        loop_d    = loop_q;
        rep_d     = rep_q;
        row_d     = row_q;
        rpf_d     = rpf_q;
        issued_d  = issued_q;
        fdone_d   = fdone_q;
        data_d    = data_q;
        stop_d    = stop_q;
        done_d    = 1'b0;

        mon_beat  = MON_TVALID && MON_TREADY && MON_TLAST;
        stop_pend = stop_q || STOP;
        last_pass = (loop_q != '0) && (pass_q == loop_q - 16'd1);
        rpf_last  = (rpf_q == '0) ? '0 : rpf_q - 16'd1;
        seq_last  = seq_len_q - (AW+1)'(1);

        if (state_q != ST_IDLE) begin
            if (STOP) begin
                stop_d = 1'b1;
            end
            if (mon_beat) begin
                if (row_q == rpf_last) begin
                    row_d   = '0;
                    fdone_d = fdone_q + 32'd1;
                end else begin
                    row_d = row_q + 16'd1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (START && (SEQ_LENGTH != '0)) begin
                    seq_len_d = SEQ_LENGTH;
                    loop_d    = LOOP_COUNT;
                    rpf_d     = ROWS_PER_FRAME;
                    idx_d     = '0;
                    pass_d    = '0;
                    row_d     = '0;
                    issued_d  = '0;
                    fdone_d   = '0;
                    stop_d    = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                data_d  = tbl_rd_data[PATTERN_WIDTH-1:0];
                rep_d   = (tbl_rep == '0) ? '0 : tbl_rep - 16'd1;
                state_d = stop_pend ? ST_DRAIN : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (AXIS_OUT_TREADY) begin
                    issued_d = issued_q + 32'd1;
                    if (stop_pend) begin
                        state_d = ST_DRAIN;
                    end else if (rep_q != '0) begin
                        rep_d = rep_q - 16'd1;
                    end else if ({1'b0, idx_q} < seq_last) begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ST_FETCH;
                    end else if (last_pass) begin
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d   = '0;
                        pass_d  = pass_q + 16'd1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DRAIN: begin
                if (fdone_q == issued_q) begin
                    done_d  = 1'b1;
                    stop_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            seq_len_q <= '0;
            pass_q    <= '0;
            loop_q    <= '0;
            rep_q     <= '0;
            row_q     <= '0;
            rpf_q     <= '0;
            issued_q  <= '0;
            fdone_q   <= '0;
            data_q    <= '0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seq_len_q <= seq_len_d;
            pass_q    <= pass_d;
            loop_q    <= loop_d;
            rep_q     <= rep_d;
            row_q     <= row_d;
            rpf_q     <= rpf_d;
            issued_q  <= issued_d;
            fdone_q   <= fdone_d;
            data_q    <= data_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
        end
    end

    assign BUSY            = (state_q != ST_IDLE);
    assign DONE            = done_q;
    assign FRAMES_ISSUED   = issued_q;
    assign FRAMES_DONE     = fdone_q;
    assign AXIS_OUT_TDATA  = data_q;
    assign AXIS_OUT_TVALID = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_simframe_sched.sv
// Directed bench for simframe_sched: sequencing, backpressure, stop, config guard and reset.
module tb_simframe_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        CFG_WR_EN;
    logic [3:0]  CFG_WR_ADDR;
    logic [31:0] CFG_WR_PATTERN;
    logic [15:0] CFG_WR_REPEAT;
    logic [4:0]  SEQ_LENGTH;
    logic [15:0] LOOP_COUNT;
    logic [15:0] ROWS_PER_FRAME;
    logic        START;
    logic        STOP;
    logic        BUSY;
    logic        DONE;
    logic [31:0] FRAMES_ISSUED;
    logic [31:0] FRAMES_DONE;
    logic [31:0] AXIS_OUT_TDATA;
    logic        AXIS_OUT_TVALID;
    logic        AXIS_OUT_TREADY;
    logic        MON_TVALID;
    logic        MON_TREADY;
    logic        MON_TLAST;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_pulses = 0;
    logic [31:0] hs_data[$];
    int          hs_cyc[$];

    simframe_sched #(
        .PATTERN_WIDTH (32),
        .TABLE_DEPTH   (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .CFG_WR_EN       (CFG_WR_EN),
        .CFG_WR_ADDR     (CFG_WR_ADDR),
        .CFG_WR_PATTERN  (CFG_WR_PATTERN),
        .CFG_WR_REPEAT   (CFG_WR_REPEAT),
        .SEQ_LENGTH      (SEQ_LENGTH),
        .LOOP_COUNT      (LOOP_COUNT),
        .ROWS_PER_FRAME  (ROWS_PER_FRAME),
        .START           (START),
        .STOP            (STOP),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .FRAMES_ISSUED   (FRAMES_ISSUED),
        .FRAMES_DONE     (FRAMES_DONE),
        .AXIS_OUT_TDATA  (AXIS_OUT_TDATA),
        .AXIS_OUT_TVALID (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY (AXIS_OUT_TREADY),
        .MON_TVALID      (MON_TVALID),
        .MON_TREADY      (MON_TREADY),
        .MON_TLAST       (MON_TLAST)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes and DONE pulses are logged just after the falling edge, once inputs have settled.
    always @(negedge clk) begin
        #1;
        if (!reset && AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
            hs_data.push_back(AXIS_OUT_TDATA);
            hs_cyc.push_back(cyc);
        end
        if (DONE) done_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] pat, input logic [15:0] rep);
        CFG_WR_EN      = 1'b1;
        CFG_WR_ADDR    = addr;
        CFG_WR_PATTERN = pat;
        CFG_WR_REPEAT  = rep;
        @(negedge clk);
        CFG_WR_EN = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] seq, input logic [15:0] loops, input logic [15:0] rpf);
        SEQ_LENGTH     = seq;
        LOOP_COUNT     = loops;
        ROWS_PER_FRAME = rpf;
        START          = 1'b1;
        @(negedge clk);
        START = 1'b0;
    endtask

    task automatic beat();
        MON_TVALID = 1'b1;
        MON_TREADY = 1'b1;
        MON_TLAST  = 1'b1;
        @(negedge clk);
        MON_TVALID = 1'b0;
        MON_TREADY = 1'b0;
        MON_TLAST  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !DONE; i++) @(negedge clk);
        check(tag, {31'd0, DONE}, 32'd1);
        check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    endtask

    task automatic clear_log();
        hs_data.delete();
        hs_cyc.delete();
    endtask

    initial begin
        logic [31:0] exp_seq[8]  = '{32'h1, 32'h2, 32'h2, 32'h3, 32'h1, 32'h2, 32'h2, 32'h3};
        int          exp_gap[7]  = '{2, 1, 2, 2, 2, 1, 2};
        int          n;
        int          dp0;
        logic        stable;
        logic        seen_busy;
        logic        seen_done;

        reset = 1'b1;
        CFG_WR_EN = 1'b0; CFG_WR_ADDR = '0; CFG_WR_PATTERN = '0; CFG_WR_REPEAT = '0;
        SEQ_LENGTH = '0; LOOP_COUNT = '0; ROWS_PER_FRAME = '0;
        START = 1'b0; STOP = 1'b0; AXIS_OUT_TREADY = 1'b1;
        MON_TVALID = 1'b0; MON_TREADY = 1'b0; MON_TLAST = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, BUSY}, 32'd0);
        check("rst_done",   {31'd0, DONE}, 32'd0);
        check("rst_tvalid", {31'd0, AXIS_OUT_TVALID}, 32'd0);
        check("rst_tdata",  AXIS_OUT_TDATA, 32'd0);
        check("rst_issued", FRAMES_ISSUED, 32'd0);
        check("rst_fdone",  FRAMES_DONE, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single entry, repeat 3, two rows per frame
        cfg_write(4'd0, 32'hA5A5A5A5, 16'd3);
        clear_log();
        start_run(5'd1, 16'd1, 16'd2);
        check("t1_fetch_busy",   {31'd0, BUSY}, 32'd1);
        check("t1_fetch_tvalid", {31'd0, AXIS_OUT_TVALID}, 32'd0);
        @(negedge clk);
        check("t1_issue_tvalid", {31'd0, AXIS_OUT_TVALID}, 32'd1);
        check("t1_issue_tdata",  AXIS_OUT_TDATA, 32'hA5A5A5A5);
        repeat (4) @(negedge clk);
        check("t1_hs_count", hs_data.size(), 32'd3);
        for (int i = 0; i < 3 && i < hs_data.size(); i++) check("t1_hs_data", hs_data[i], 32'hA5A5A5A5);
        if (hs_cyc.size() == 3) check("t1_no_bubble", hs_cyc[2] - hs_cyc[0], 32'd2);
        check("t1_issued", FRAMES_ISSUED, 32'd3);
        check("t1_drain_tvalid", {31'd0, AXIS_OUT_TVALID}, 32'd0);
        repeat (5) beat();
        check("t1_fdone5", FRAMES_DONE, 32'd2);
        check("t1_busy5",  {31'd0, BUSY}, 32'd1);
        beat();
        check("t1_fdone6", FRAMES_DONE, 32'd3);
        check("t1_done_early", {31'd0, DONE}, 32'd0);
        @(negedge clk);
        check("t1_done_pulse", {31'd0, DONE}, 32'd1);
        check("t1_busy_fall",  {31'd0, BUSY}, 32'd0);
        @(negedge clk);
        check("t1_done_single", {31'd0, DONE}, 32'd0);

        // Sequence order across two passes, one row per frame
        cfg_write(4'd0, 32'h1, 16'd1);
        cfg_write(4'd1, 32'h2, 16'd2);
        cfg_write(4'd2, 32'h3, 16'd0);
        clear_log();
        start_run(5'd3, 16'd2, 16'd1);
        for (int i = 0; i < 60 && !(hs_data.size() >= 8 && !AXIS_OUT_TVALID); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t2_hs_count", hs_data.size(), 32'd8);
        for (int i = 0; i < 8 && i < hs_data.size(); i++) check($sformatf("t2_data%0d", i), hs_data[i], exp_seq[i]);
        for (int i = 0; i < 7 && i + 1 < hs_cyc.size(); i++)
            check($sformatf("t2_gap%0d", i), hs_cyc[i+1] - hs_cyc[i], exp_gap[i]);
        check("t2_issued", FRAMES_ISSUED, 32'd8);
        repeat (8) beat();
        wait_done("t2_done", 10);
        check("t2_fdone", FRAMES_DONE, 32'd8);
        @(negedge clk);

        // Endless run, backpressure after five handshakes, then graceful stop
        clear_log();
        dp0 = done_pulses;
        start_run(5'd3, 16'd0, 16'd1);
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            @(negedge clk);
            if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) n++;
        end
        check("t3_reach5", n, 32'd5);
        @(negedge clk);
        AXIS_OUT_TREADY = 1'b0;
        check("t3_bubble", {31'd0, AXIS_OUT_TVALID}, 32'd0);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!(AXIS_OUT_TVALID === 1'b1 && AXIS_OUT_TDATA === 32'h2 && FRAMES_ISSUED === 32'd5)) stable = 1'b0;
        end
        check("t3_bp_stable", {31'd0, stable}, 32'd1);
        check("t3_bp_tdata", AXIS_OUT_TDATA, 32'h2);
        STOP = 1'b1;
        @(negedge clk);
        STOP = 1'b0;
        AXIS_OUT_TREADY = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("t3_stop_tvalid", {31'd0, AXIS_OUT_TVALID}, 32'd0);
        check("t3_stop_issued", FRAMES_ISSUED, 32'd6);
        check("t3_stop_busy",   {31'd0, BUSY}, 32'd1);
        check("t3_hs_count", hs_data.size(), 32'd6);
        if (hs_data.size() == 6) check("t3_last_data", hs_data[5], 32'h2);
        repeat (5) beat();
        @(negedge clk);
        check("t3_fdone5", FRAMES_DONE, 32'd5);
        check("t3_no_done", done_pulses - dp0, 32'd0);
        beat();
        wait_done("t3_done", 10);
        check("t3_fdone", FRAMES_DONE, 32'd6);
        @(negedge clk);

        // START with empty sequence, then a write attempted while busy
        seen_busy = 1'b0;
        seen_done = 1'b0;
        start_run(5'd0, 16'd1, 16'd1);
        repeat (5) begin
            seen_busy |= BUSY;
            seen_done |= DONE;
            @(negedge clk);
        end
        check("t4_empty_busy", {31'd0, seen_busy}, 32'd0);
        check("t4_empty_done", {31'd0, seen_done}, 32'd0);
        start_run(5'd1, 16'd1, 16'd1);
        cfg_write(4'd0, 32'hDEADBEEF, 16'd5);
        repeat (5) @(negedge clk);
        beat();
        wait_done("t4_run1_done", 10);
        @(negedge clk);
        clear_log();
        start_run(5'd1, 16'd1, 16'd1);
        repeat (5) @(negedge clk);
        check("t4_hs_count", hs_data.size(), 32'd1);
        if (hs_data.size() >= 1) check("t4_table_kept", hs_data[0], 32'h1);
        check("t4_issued", FRAMES_ISSUED, 32'd1);
        beat();
        wait_done("t4_run2_done", 10);
        @(negedge clk);

        // Reset in the middle of an endless run, then a fresh run
        start_run(5'd1, 16'd0, 16'd1);
        for (int i = 0; i < 20 && !AXIS_OUT_TVALID; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5 && !AXIS_OUT_TVALID; i++) @(negedge clk);
        check("t5_pre_tvalid", {31'd0, AXIS_OUT_TVALID}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_tvalid", {31'd0, AXIS_OUT_TVALID}, 32'd0);
        check("t5_rst_busy",   {31'd0, BUSY}, 32'd0);
        check("t5_rst_issued", FRAMES_ISSUED, 32'd0);
        check("t5_rst_fdone",  FRAMES_DONE, 32'd0);
        check("t5_rst_tdata",  AXIS_OUT_TDATA, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        clear_log();
        start_run(5'd1, 16'd1, 16'd1);
        repeat (5) @(negedge clk);
        check("t5_hs_count", hs_data.size(), 32'd1);
        if (hs_data.size() >= 1) check("t5_data", hs_data[0], 32'h1);
        check("t5_issued", FRAMES_ISSUED, 32'd1);
        beat();
        wait_done("t5_done", 10);
        check("t5_fdone", FRAMES_DONE, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
